// File: rtl/conv2d_writeback_pkg.sv
// Shared definitions for the conv2d window-stream writeback block.
// Holds the sequencing state encoding, default image geometry and
// kernel tap bookkeeping used by the top and the MAC stage.
package conv2d_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SLIDE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ROWS_DEF  = 5;
  localparam int COLS_DEF  = 5;
  localparam int NUM_TAPS  = 9;
  localparam int KADDR_W   = 4;

endpackage

// File: rtl/conv2d_writeback_mac9.sv
// 3x3 multiply-accumulate with shift and saturation.
// Ports:
//   i_clk, i_rst    clock, async active-high reset
//   i_valid         taps/coeffs hold a complete window this cycle
//   i_taps          9 unsigned samples, tap k at [k*DataBitWidth +: DataBitWidth]
//   i_coeffs        9 signed coefficients, tap k at [k*CoeffBitWidth +: CoeffBitWidth]
//   o_valid         one-cycle pulse, two edges after i_valid
//   o_res           saturated result, aligned with o_valid
module conv2d_writeback_mac9
  import conv2d_writeback_pkg::*;
#(
  parameter int DataBitWidth  = 12,
  parameter int CoeffBitWidth = 8,
  parameter int ShiftAmount   = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  input  logic [NUM_TAPS*DataBitWidth-1:0]     i_taps,
  input  logic [NUM_TAPS*CoeffBitWidth-1:0]    i_coeffs,
  output logic                                 o_valid,
  output logic [DataBitWidth-1:0]              o_res
);

  localparam int AccW = DataBitWidth + CoeffBitWidth + 5;

  logic signed [AccW-1:0] w_prod [NUM_TAPS];
  logic signed [AccW-1:0] w_sum;
  logic signed [AccW-1:0] w_shift;
  logic signed [AccW-1:0] w_max;
  logic signed [AccW-1:0] r_acc;
  logic                   r_acc_valid;

  // Samples are zero-extended so they multiply as non-negative signed values.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_prod
    logic signed [AccW-1:0] w_tap_ext;
    logic signed [AccW-1:0] w_coef_ext;
    assign w_tap_ext  = {{(AccW-DataBitWidth){1'b0}}, i_taps[k*DataBitWidth +: DataBitWidth]};
    assign w_coef_ext = {{(AccW-CoeffBitWidth){i_coeffs[(k+1)*CoeffBitWidth-1]}},
                         i_coeffs[k*CoeffBitWidth +: CoeffBitWidth]};
    assign w_prod[k]  = w_tap_ext * w_coef_ext;
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      w_sum = w_sum + w_prod[k];
    end
  end

  assign w_shift = r_acc >>> ShiftAmount;
  assign w_max   = {{(AccW-DataBitWidth){1'b0}}, {DataBitWidth{1'b1}}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      o_valid     <= 1'b0;
      o_res       <= '0;
    end else begin
      r_acc       <= w_sum;
      r_acc_valid <= i_valid;
      o_valid     <= r_acc_valid;
      if (w_shift[AccW-1]) begin
        o_res <= '0;
      end else if (w_shift > w_max) begin
        o_res <= '1;
      end else begin
        o_res <= w_shift[DataBitWidth-1:0];
      end
    end
  end

endmodule

// File: rtl/conv2d_writeback.sv
// Consumer of the conv2d window stream: collects 3x3 window samples,
// zeroes padded taps, convolves with a loadable signed kernel and emits
// one result pixel per window in raster order.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_start           begin a frame (IDLE) / acknowledge completion (DONE)
//   i_in_valid,i_d_in window sample strobe and data
//   i_k_we,i_k_addr,i_k_data  kernel tap write (IDLE/DONE only, taps 0..8)
//   o_write_address   raster result address
//   o_d_out, o_wr_en  result pixel and its one-cycle strobe
//   o_ready           frame complete, held until i_start in DONE
//
// state   | meaning
// IDLE    | waiting for start, kernel writable
// FILL    | collecting the first two columns of a row
// SLIDE   | each completed column closes a window and issues a result
// DONE    | frame finished, kernel writable, start returns to IDLE
module conv2d_writeback
  import conv2d_writeback_pkg::*;
#(
  parameter int AddressBitWidth = 17,
  parameter int DataBitWidth    = 12,
  parameter int CoeffBitWidth   = 8,
  parameter int ShiftAmount     = 0,
  parameter int NoOfRows        = ROWS_DEF,
  parameter int NoOfColumns     = COLS_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_in_valid,
  input  logic [DataBitWidth-1:0]    i_d_in,
  input  logic                       i_k_we,
  input  logic [KADDR_W-1:0]         i_k_addr,
  input  logic [CoeffBitWidth-1:0]   i_k_data,
  output logic [AddressBitWidth-1:0] o_write_address,
  output logic [DataBitWidth-1:0]    o_d_out,
  output logic                       o_wr_en,
  output logic                       o_ready
);

  localparam int RowW = (NoOfRows > 1) ? $clog2(NoOfRows) : 1;
  localparam int ColW = $clog2(NoOfColumns + 2);
  localparam logic [RowW-1:0] LastRow = RowW'(NoOfRows - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(NoOfColumns + 1);
  localparam logic [AddressBitWidth-1:0] LastAddr = AddressBitWidth'(NoOfRows*NoOfColumns - 1);

  state_t                       r_state;
  logic [RowW-1:0]              r_row;
  logic [ColW-1:0]              r_scol;   // sample column + 1, 0..NoOfColumns+1
  logic [1:0]                   r_tap;    // row offset + 1 within the column
  logic [DataBitWidth-1:0]      r_colbuf [2];
  logic [DataBitWidth-1:0]      r_win [NUM_TAPS];
  logic [CoeffBitWidth-1:0]     r_kernel [NUM_TAPS];
  logic                         r_win_valid;
  logic                         r_win_valid_d;
  logic [AddressBitWidth-1:0]   r_addr_cnt;
  logic [AddressBitWidth-1:0]   r_write_address;
  logic                         r_ready;

  logic                              w_busy;
  logic                              w_accept;
  logic                              w_pad;
  logic [DataBitWidth-1:0]           w_sample;
  logic [NUM_TAPS*DataBitWidth-1:0]  w_taps;
  logic [NUM_TAPS*CoeffBitWidth-1:0] w_coeffs;

  assign w_busy   = (r_state == ST_FILL) || (r_state == ST_SLIDE);
  assign w_accept = i_in_valid && w_busy;
  assign w_pad    = ((r_tap == 2'd0) && (r_row == '0)) ||
                    ((r_tap == 2'd2) && (r_row == LastRow)) ||
                    (r_scol == '0) || (r_scol == LastCol);
  assign w_sample = w_pad ? '0 : i_d_in;

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
    assign w_taps[k*DataBitWidth +: DataBitWidth]    = r_win[k];
    assign w_coeffs[k*CoeffBitWidth +: CoeffBitWidth] = r_kernel[k];
  end

  // Window tap k = 3*row_offset + column_slot; slot 0 is the oldest column.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_row           <= '0;
      r_scol          <= '0;
      r_tap           <= '0;
      r_win_valid     <= 1'b0;
      r_win_valid_d   <= 1'b0;
      r_addr_cnt      <= '0;
      r_write_address <= '0;
      r_ready         <= 1'b0;
      for (int k = 0; k < 2; k++) r_colbuf[k] <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_win[k]    <= '0;
        r_kernel[k] <= '0;
      end
    end else begin
      r_win_valid   <= 1'b0;
      r_win_valid_d <= r_win_valid;
      // Address is registered on the same edge the MAC registers its result.
      if (r_win_valid_d) begin
        r_write_address <= r_addr_cnt;
        r_addr_cnt      <= r_addr_cnt + AddressBitWidth'(1);
      end
      if (o_wr_en && (r_write_address == LastAddr) && (r_state == ST_DONE)) begin
        r_ready <= 1'b1;
      end
      if (i_k_we && !w_busy && (i_k_addr < KADDR_W'(NUM_TAPS))) begin
        r_kernel[i_k_addr] <= i_k_data;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_FILL;
            r_row      <= '0;
            r_scol     <= '0;
            r_tap      <= '0;
            r_addr_cnt <= '0;
          end
        end
        ST_FILL, ST_SLIDE: begin
          if (w_accept) begin
            if (r_tap != 2'd2) begin
              r_colbuf[r_tap[0]] <= w_sample;
              r_tap              <= r_tap + 2'd1;
            end else begin
              r_tap <= '0;
              for (int t = 0; t < 3; t++) begin
                r_win[3*t]   <= r_win[3*t+1];
                r_win[3*t+1] <= r_win[3*t+2];
              end
              r_win[2] <= r_colbuf[0];
              r_win[5] <= r_colbuf[1];
              r_win[8] <= w_sample;
              if (r_state == ST_SLIDE) r_win_valid <= 1'b1;
              if (r_scol == LastCol) begin
                r_scol <= '0;
                if (r_row == LastRow) begin
                  r_state <= ST_DONE;
                end else begin
                  r_row   <= r_row + RowW'(1);
                  r_state <= ST_FILL;
                end
              end else begin
                r_scol <= r_scol + ColW'(1);
                if (r_scol == ColW'(1)) r_state <= ST_SLIDE;
              end
            end
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_row      <= '0;
            r_scol     <= '0;
            r_tap      <= '0;
            r_addr_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  conv2d_writeback_mac9 #(
    .DataBitWidth (DataBitWidth),
    .CoeffBitWidth(CoeffBitWidth),
    .ShiftAmount  (ShiftAmount)
  ) u_mac (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (r_win_valid),
    .i_taps  (w_taps),
    .i_coeffs(w_coeffs),
    .o_valid (o_wr_en),
    .o_res   (o_d_out)
  );

  assign o_write_address = r_write_address;
  assign o_ready         = r_ready;

endmodule

// File: tb/tb_conv2d_writeback.sv
module tb_conv2d_writeback;

  localparam int R = 5;
  localparam int C = 5;
  localparam int SHIFT = 0;
  localparam int NPIX = R * C;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_in_valid, i_k_we;
  logic [11:0] i_d_in;
  logic [3:0]  i_k_addr;
  logic [7:0]  i_k_data;
  logic [16:0] o_write_address;
  logic [11:0] o_d_out;
  logic        o_wr_en, o_ready;

  conv2d_writeback dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (i_start),
    .i_in_valid     (i_in_valid),
    .i_d_in         (i_d_in),
    .i_k_we         (i_k_we),
    .i_k_addr       (i_k_addr),
    .i_k_data       (i_k_data),
    .o_write_address(o_write_address),
    .o_d_out        (o_d_out),
    .o_wr_en        (o_wr_en),
    .o_ready        (o_ready)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     addr;
    int     data;
    longint cyc;
  } exp_t;

  exp_t q[$];
  int   img [R][C];
  int   kern [9];
  int   got_px [NPIX];
  int   writes_seen;
  bit   ready_exp;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Plain 2D convolution with zero padding, then shift and clamp.
  function automatic int model_px(int r, int c);
    int acc = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r+dr >= 0 && r+dr < R && c+dc >= 0 && c+dc < C)
          acc += kern[3*(dr+1)+(dc+1)] * img[r+dr][c+dc];
    acc = acc >>> SHIFT;
    if (acc < 0) return 0;
    if (acc > 4095) return 4095;
    return acc;
  endfunction

  // Compare process: every result strobe is checked against the model queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      ready_exp = 1'b0;
      check("wr_en_in_reset", o_wr_en, 0);
    end else begin
      if (o_wr_en) begin
        if (q.size() == 0) begin
          check("unexpected_wr_en", 1, 0);
        end else begin
          e = q.pop_front();
          check("wr_addr", o_write_address, e.addr);
          check("wr_data", o_d_out, e.data);
          check("wr_latency_cycle", cyc, e.cyc);
          if (o_write_address < NPIX) got_px[o_write_address] = o_d_out;
          writes_seen++;
        end
      end
      check("ready", o_ready, ready_exp);
      if (o_wr_en && o_write_address == NPIX-1) ready_exp = 1'b1;
      if (i_start && ready_exp) ready_exp = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input int k[9], input bit all_taps);
    for (int i = 0; i < 9; i++) begin
      if (all_taps || i >= 4) begin
        i_k_we = 1'b1; i_k_addr = 4'(i); i_k_data = 8'(k[i]);
        kern[i] = k[i];
        tick();
      end
    end
    for (int a = 9; a < 16; a++) begin
      i_k_we = 1'b1; i_k_addr = 4'(a); i_k_data = 8'($urandom_range(0, 255));
      tick();
    end
    i_k_we = 1'b0;
  endtask

  task automatic stream_frame(input int gap_mode, input int garb_mode, input int inject_at,
                              input int abort_after, output bit aborted);
    int idx = 0;
    exp_t e;
    aborted = 0;
    for (int r = 0; r < R && !aborted; r++) begin
      for (int sc = 0; sc <= C+1 && !aborted; sc++) begin
        for (int t = 0; t < 3 && !aborted; t++) begin
          int rr = r - 1 + t;
          int cc = sc - 1;
          int d;
          if (rr < 0 || rr >= R || cc < 0 || cc >= C)
            d = (garb_mode == 1) ? 4095 : int'($urandom_range(0, 4095));
          else
            d = img[rr][cc];
          if (t == 2 && sc >= 2) begin
            e.addr = r*C + (sc-2);
            e.data = model_px(r, sc-2);
            e.cyc  = cyc + 3;
            q.push_back(e);
          end
          if (idx == inject_at) begin
            i_start = 1'b1; i_k_we = 1'b1;
            i_k_addr = 4'(idx % 9); i_k_data = 8'($urandom_range(0, 255));
          end
          i_in_valid = 1'b1; i_d_in = 12'(d);
          tick();
          i_in_valid = 1'b0; i_start = 1'b0; i_k_we = 1'b0;
          i_d_in = 12'($urandom_range(0, 4095));
          if (gap_mode == 1) tick();
          else if (gap_mode == 2) repeat ($urandom_range(0, 2)) tick();
          idx++;
          if (abort_after > 0 && writes_seen >= abort_after) aborted = 1;
        end
      end
    end
  endtask

  task automatic run_frame(input int gap_mode, input int garb_mode, input int inject_at,
                           input int abort_after, output bit aborted);
    int i;
    writes_seen = 0;
    for (int a = 0; a < NPIX; a++) got_px[a] = -1;
    i_start = 1'b1; tick(); i_start = 1'b0;
    stream_frame(gap_mode, garb_mode, inject_at, abort_after, aborted);
    if (aborted) return;
    for (i = 0; i < 100 && !o_ready; i++) tick();
    check("ready_rise", o_ready, 1);
    check("write_count", writes_seen, NPIX);
    if (!o_ready) begin
      $display("FAIL ready_timeout: frame did not complete");
      n_err++;
    end
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    check("ready_drop", o_ready, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_en", o_wr_en, 0);
    check("rst_d_out", o_d_out, 0);
    check("rst_addr", o_write_address, 0);
    check("rst_ready", o_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k[9];
    bit  ab;
    rst = 1'b1; i_start = 0; i_in_valid = 0; i_k_we = 0;
    i_d_in = '0; i_k_addr = '0; i_k_data = '0;
    for (int i = 0; i < 9; i++) kern[i] = 0;
    writes_seen = 0; ready_exp = 0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Identity kernel, pixel = r*5+c.
    for (int i = 0; i < 9; i++) k[i] = (i == 4) ? 1 : 0;
    load_kernel(k, 1);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = r*C + c;
    run_frame(0, 0, -1, 0, ab);
    for (int a = 0; a < NPIX; a++) check("identity_px", got_px[a], a);

    // All-ones kernel and image, 0xFFF on pads, 1-0-1 valid toggling.
    for (int i = 0; i < 9; i++) k[i] = 1;
    load_kernel(k, 1);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = 1;
    run_frame(1, 1, -1, 0, ab);
    check("ones_addr0", got_px[0], 4);
    check("ones_addr1", got_px[1], 6);
    check("ones_addr2", got_px[2], 6);
    check("ones_addr12", got_px[12], 9);
    check("ones_addr20", got_px[20], 4);
    check("ones_addr24", got_px[24], 4);

    // Positive saturation.
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = 4095;
    run_frame(2, 1, -1, 0, ab);
    for (int a = 0; a < NPIX; a++) check("sat_high_px", got_px[a], 4095);

    // Negative clamp.
    for (int i = 0; i < 9; i++) k[i] = -1;
    load_kernel(k, 1);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = $urandom_range(0, 4095);
    run_frame(2, 0, -1, 0, ab);
    for (int a = 0; a < NPIX; a++) check("sat_low_px", got_px[a], 0);

    // Random kernel/image with start and k_we injected mid-frame.
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(0, 255)) - 128;
      load_kernel(k, 1);
      for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = $urandom_range(0, 4095);
      run_frame(2, 0, 20 + 7*n, 0, ab);
    end

    // Reset after the 12th write aborts the frame.
    for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(0, 15)) - 4;
    load_kernel(k, 1);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = $urandom_range(0, 300);
    run_frame(2, 0, -1, 12, ab);
    check("abort_taken", ab, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) kern[i] = 0;
    repeat (20) tick();

    // Reload only taps 4..8; taps 0..3 rely on the reset clear.
    for (int i = 0; i < 9; i++) k[i] = int'($urandom_range(1, 12));
    load_kernel(k, 0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) img[r][c] = $urandom_range(0, 300);
    run_frame(0, 0, 33, 0, ab);
    check("post_reset_first_addr_seen", (got_px[0] >= 0) ? 1 : 0, 1);

    repeat (5) tick();
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
